bram_playback: RTL

Read-side companion to the switch-capture writer: on a start pulse it walks BRAM port B from address 0 through a latched sample count and streams each stored 2-bit switch sample out over a valid/ready interface. Optional inter-sample pacing lets a slow consumer such as an LED or UART formatter keep up. It sits beside the writer on the dual-port BRAM. Its start pulse is normally driven from the writer's interrupt or a second button, and its count from the writer's address counter.

---
 rtl/bram_playback_pkg.sv | 17 +
 rtl/bram_playback_if.sv | 15 +
 rtl/bram_playback_pace_timer.sv | 25 ++
 rtl/bram_playback.sv | 116 +++++++++++
 4 files changed

// File: rtl/bram_playback_pkg.sv
// bram_pkg: state encodings and widths shared by the BRAM capture writer and playback reader
package bram_pkg;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;
    localparam int SAMPLE_LSB = 0;
    localparam int SAMPLE_MSB = 1;
    localparam int SAMPLE_W   = SAMPLE_MSB - SAMPLE_LSB + 1;
    localparam int TMR_W      = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;
endpackage

// File: rtl/bram_playback_if.sv
// bram_playback_if: BRAM port-B read bus plus the sample valid/ready stream
interface bram_playback_if #(
    parameter int ADDR_W = bram_pkg::DEF_ADDR_W,
    parameter int DATA_W = bram_pkg::DEF_DATA_W
);
    logic                        enb;
    logic [ADDR_W-1:0]           addrb;
    logic [DATA_W-1:0]           doutb;
    logic [bram_pkg::SAMPLE_W-1:0] sample;
    logic                        valid;
    logic                        ready;

    modport master (output enb, addrb, sample, valid, input doutb, ready);
    modport slave  (input enb, addrb, sample, valid, output doutb, ready);
endinterface

// File: rtl/bram_playback_pace_timer.sv
// pace_timer: loadable down-counter that stops at zero; times both BRAM latency and inter-sample gaps
module pace_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);
    logic [W-1:0] cnt_q, cnt_d;

    // load takes priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = i_load ? i_value : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    end

    // counter register, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_zero = cnt_q == '0;
endmodule

// File: rtl/bram_playback.sv
// bram_playback: walks BRAM port B over a latched count and streams 2-bit samples on valid/ready
module bram_playback
    import bram_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1,
    parameter int PACE     = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_count,
    output logic              o_busy,
    output logic              o_done,
    bram_playback_if.master   bus
);
    localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(READ_LAT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(PACE > 0 ? PACE - 1 : 0);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, count_q, count_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d, enb_q, enb_d, busy_q, busy_d, done_q, done_d;
    logic                tmr_load, tmr_zero, last;
    logic [DATA_W-1:0]   unused_doutb;

    assign unused_doutb = bus.doutb;
    assign last         = addr_q == count_q - ADDR_W'(1);
    // READ arms the latency count; PRESENT keeps the gap count armed until the handshake
    assign tmr_load     = state_q == READ || state_q == PRESENT;

    pace_timer #(.W(TMR_W)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (tmr_load),
        .i_value (state_q == READ ? LAT_LOAD : GAP_LOAD),
        .o_zero  (tmr_zero)
    );

    // playback FSM with abort overriding every state; outputs are decoded from the next state
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        sample_d = sample_q;
        done_d   = 1'b0;
        if (i_abort) begin
            state_d  = IDLE;
            addr_d   = '0;
            sample_d = '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    if (i_count != '0) begin
                        count_d = i_count;
                        addr_d  = '0;
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                READ:    state_d = WAIT;
                WAIT: if (tmr_zero) begin
                    sample_d = bus.doutb[SAMPLE_MSB:SAMPLE_LSB];
                    state_d  = PRESENT;
                end
                PRESENT: if (bus.ready) begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = PACE > 0 ? GAP : READ;
                    end
                end
                GAP:     state_d = tmr_zero ? READ : GAP;
                default: state_d = IDLE;
            endcase
        end
        valid_d = state_d == PRESENT;
        enb_d   = state_d == READ;
        busy_d  = state_d != IDLE;
    end

    // state, address/count and registered outputs, all cleared asynchronously
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            enb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            enb_q    <= enb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.enb    = enb_q;
    assign bus.addrb  = addr_q;
    assign bus.sample = sample_q;
    assign bus.valid  = valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
endmodule
